dmac_axi_mem_slave: RTL and testbench

- Synthesizable AXI3 slave memory that responds to DMAC_TOP's AXI master ports (AW/W/B/AR/R).
- Used in FPGA/emulation builds and RTL-only regressions in place of the behavioural memory model.
- Backed by a word-addressed dual-port SRAM.
- One write transaction and one read transaction may be in flight at once, independently of each other.

---
 rtl/dmac_axi_pkg.sv | 27 ++
 rtl/dmac_sram_2p.sv | 32 +++
 rtl/dmac_axi_mem_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_dmac_axi_mem_slave.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the DMAC memory slave.
package dmac_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_4B = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dmac_sram_2p.sv
// Word-wide dual-port SRAM: byte-enabled write port, registered read port.
// Same-address read and write in one cycle returns the old word.
module dmac_sram_2p #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wbe,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmac_axi_mem_slave.sv
// AXI3 slave memory with independent write and read FSMs over a 2-port SRAM.
// Only INCR, 4-byte, aligned bursts are OKAY; beats past the end are dropped.
module dmac_axi_mem_slave
    import dmac_axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   awid_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic [3:0]        awlen_i,
    input  logic [2:0]        awsize_i,
    input  logic [1:0]        awburst_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [ID_W-1:0]   wid_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wlast_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [ID_W-1:0]   bid_o,
    output logic [1:0]        bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [ADDR_W-1:0] araddr_i,
    input  logic [3:0]        arlen_i,
    input  logic [2:0]        arsize_i,
    input  logic [1:0]        arburst_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [ID_W-1:0]   rid_o,
    output logic [31:0]       rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              rvalid_o,
    input  logic              rready_i
);

    localparam int unsigned WA_W   = ADDR_W - 2;
    localparam int unsigned MEM_AW = $clog2(DEPTH);

    // ---------------- write channel ----------------
    wr_state_e         r_wstate, w_wstate_nxt;
    logic [ID_W-1:0]   r_wid, w_wid_nxt;
    logic [WA_W-1:0]   r_waddr, w_waddr_nxt;
    logic [3:0]        r_wlen, w_wlen_nxt;
    logic [3:0]        r_wbeat, w_wbeat_nxt;
    logic              r_werr, w_werr_nxt;
    logic              r_awready, r_wready, r_bvalid;
    logic              w_mem_we;

    logic w_aw_hs, w_w_hs, w_b_hs, w_waddr_ok, w_wlast_exp, w_aw_err;

    assign w_aw_hs     = awvalid_i && r_awready;
    assign w_w_hs      = wvalid_i && r_wready;
    assign w_b_hs      = r_bvalid && bready_i;
    assign w_waddr_ok  = r_waddr < WA_W'(DEPTH);
    assign w_wlast_exp = r_wbeat == r_wlen;
    assign w_aw_err    = (awburst_i != BURST_INCR) || (awsize_i != SIZE_4B) ||
                         (awaddr_i[1:0] != 2'b00);

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wid_nxt    = r_wid;
        w_waddr_nxt  = r_waddr;
        w_wlen_nxt   = r_wlen;
        w_wbeat_nxt  = r_wbeat;
        w_werr_nxt   = r_werr;
        w_mem_we     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_wid_nxt    = awid_i;
                    w_waddr_nxt  = awaddr_i[ADDR_W-1:2];
                    w_wlen_nxt   = awlen_i;
                    w_wbeat_nxt  = 4'd0;
                    w_werr_nxt   = w_aw_err;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (w_w_hs) begin
                    w_mem_we    = w_waddr_ok;
                    // Burst length is set by AW; a misplaced wlast only flags the error.
                    if (!w_waddr_ok || (wlast_i != w_wlast_exp)) begin
                        w_werr_nxt = 1'b1;
                    end
                    w_waddr_nxt = r_waddr + WA_W'(1);
                    w_wbeat_nxt = r_wbeat + 4'd1;
                    if (w_wlast_exp) begin
                        w_wstate_nxt = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (w_b_hs) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_wid     <= w_wid_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wlen    <= w_wlen_nxt;
            r_wbeat   <= w_wbeat_nxt;
            r_werr    <= w_werr_nxt;
            r_awready <= w_wstate_nxt == W_IDLE;
            r_wready  <= w_wstate_nxt == W_DATA;
            r_bvalid  <= w_wstate_nxt == W_RESP;
        end
    end

    assign awready_o = r_awready;
    assign wready_o  = r_wready;
    assign bvalid_o  = r_bvalid;
    assign bid_o     = r_wid;
    assign bresp_o   = (r_bvalid && r_werr) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read channel ----------------
    rd_state_e         r_rstate, w_rstate_nxt;
    logic [ID_W-1:0]   r_rid, w_rid_nxt;
    logic [WA_W-1:0]   r_raddr, w_raddr_nxt;
    logic [WA_W-1:0]   w_ram_raddr;
    logic [3:0]        r_rlen, w_rlen_nxt;
    logic [3:0]        r_rbeat, w_rbeat_nxt;
    logic              r_rerr, w_rerr_nxt;
    logic              r_arready, r_rvalid;
    logic [31:0]       w_ram_rdata;

    logic w_ar_hs, w_r_hs, w_raddr_ok, w_rlast, w_ar_err;

    assign w_ar_hs    = arvalid_i && r_arready;
    assign w_r_hs     = r_rvalid && rready_i;
    assign w_raddr_ok = r_raddr < WA_W'(DEPTH);
    assign w_rlast    = r_rbeat == r_rlen;
    assign w_ar_err   = (arburst_i != BURST_INCR) || (arsize_i != SIZE_4B) ||
                        (araddr_i[1:0] != 2'b00);

    // RAM address tracks the beat on display so stalled data stays put.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rid_nxt    = r_rid;
        w_raddr_nxt  = r_raddr;
        w_rlen_nxt   = r_rlen;
        w_rbeat_nxt  = r_rbeat;
        w_rerr_nxt   = r_rerr;
        w_ram_raddr  = r_raddr;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rid_nxt    = arid_i;
                    w_raddr_nxt  = araddr_i[ADDR_W-1:2];
                    w_rlen_nxt   = arlen_i;
                    w_rbeat_nxt  = 4'd0;
                    w_rerr_nxt   = w_ar_err;
                    w_ram_raddr  = araddr_i[ADDR_W-1:2];
                    w_rstate_nxt = R_FETCH;
                end
            end
            R_FETCH: begin
                w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (w_r_hs) begin
                    if (w_rlast) begin
                        w_rstate_nxt = R_IDLE;
                    end else begin
                        w_raddr_nxt = r_raddr + WA_W'(1);
                        w_rbeat_nxt = r_rbeat + 4'd1;
                        w_ram_raddr = r_raddr + WA_W'(1);
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_rerr    <= 1'b0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_rid     <= w_rid_nxt;
            r_raddr   <= w_raddr_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rbeat   <= w_rbeat_nxt;
            r_rerr    <= w_rerr_nxt;
            r_arready <= w_rstate_nxt == R_IDLE;
            r_rvalid  <= w_rstate_nxt == R_DATA;
        end
    end

    assign arready_o = r_arready;
    assign rvalid_o  = r_rvalid;
    assign rid_o     = r_rid;
    assign rlast_o   = r_rvalid && w_rlast;
    assign rdata_o   = (r_rvalid && w_raddr_ok) ? w_ram_rdata : 32'd0;
    assign rresp_o   = (r_rvalid && (r_rerr || !w_raddr_ok)) ? RESP_SLVERR : RESP_OKAY;

    dmac_sram_2p #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_waddr[MEM_AW-1:0]),
        .i_wdata (wdata_i),
        .i_wbe   (wstrb_i),
        .i_raddr (w_ram_raddr[MEM_AW-1:0]),
        .o_rdata (w_ram_rdata)
    );

    logic w_unused;
    assign w_unused = ^{wid_i};

endmodule

// File: tb/tb_dmac_axi_mem_slave.sv
// Directed + randomized bench for dmac_axi_mem_slave against an array memory model.
module tb_dmac_axi_mem_slave;
    import dmac_axi_pkg::*;

    localparam int unsigned ID_W      = 4;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DEPTH     = 4096;
    localparam int unsigned MEM_BYTES = DEPTH * 4;

    logic              clk;
    logic              rst_n;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic [3:0]        awlen_i;
    logic [2:0]        awsize_i;
    logic [1:0]        awburst_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [ID_W-1:0]   wid_i;
    logic [31:0]       wdata_i;
    logic [3:0]        wstrb_i;
    logic              wlast_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [ID_W-1:0]   bid_o;
    logic [1:0]        bresp_o;
    logic              bvalid_o;
    logic              bready_i;
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic [3:0]        arlen_i;
    logic [2:0]        arsize_i;
    logic [1:0]        arburst_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   rid_o;
    logic [31:0]       rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;

    dmac_axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]     model [DEPTH];
    logic [31:0]     wbuf  [16];
    logic [3:0]      sbuf  [16];
    logic [31:0]     rd_data [16];
    logic [1:0]      rd_resp [16];
    logic            rd_last [16];
    logic [ID_W-1:0] rd_id   [16];
    int              rd_n;
    logic [1:0]      wr_resp;
    logic [ID_W-1:0] wr_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: linear word stepping, strobed bytes, in-range beats only.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [1:0] burst, input logic [2:0] size,
                                               input int bad_last);
        bit err;
        err = (burst != BURST_INCR) || (size != SIZE_4B) || (addr[1:0] != 2'b00);
        for (int i = 0; i <= len; i++) begin
            longint unsigned w;
            w = 64'(addr >> 2) + 64'(i);
            if (w >= 64'(DEPTH)) err = 1'b1;
            else begin
                for (int b = 0; b < 4; b++) begin
                    if (sbuf[i][b]) model[int'(w)][8*b +: 8] = wbuf[i][8*b +: 8];
                end
            end
            if (i == bad_last) err = 1'b1;
        end
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] addr, input int i);
        longint unsigned w;
        w = 64'(addr >> 2) + 64'(i);
        if (w >= 64'(DEPTH)) return 32'd0;
        return model[int'(w)];
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [31:0] addr, input int i,
                                             input logic [1:0] burst, input logic [2:0] size);
        longint unsigned w;
        bit err;
        w   = 64'(addr >> 2) + 64'(i);
        err = (burst != BURST_INCR) || (size != SIZE_4B) || (addr[1:0] != 2'b00);
        return (err || (w >= 64'(DEPTH))) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size, input int bad_last);
        @(negedge clk);
        awid_i = id; awaddr_i = addr; awlen_i = 4'(len); awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        for (int c = 0; c < 100 && !awready_o; c++) @(negedge clk);
        check("awready", 32'(awready_o), 32'd1);
        @(negedge clk);
        awvalid_i = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wid_i = id; wdata_i = wbuf[i]; wstrb_i = sbuf[i];
            wlast_i = (i == len) ^ (i == bad_last);
            wvalid_i = 1'b1;
            for (int c = 0; c < 100 && !wready_o; c++) @(negedge clk);
            check("wready", 32'(wready_o), 32'd1);
            @(negedge clk);
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
        check("b_latency", 32'(bvalid_o), 32'd1);
        bready_i = 1'b1;
        for (int c = 0; c < 100 && !bvalid_o; c++) @(negedge clk);
        wr_resp = bresp_o;
        wr_id   = bid_o;
        @(negedge clk);
        bready_i = 1'b0;
        check("awready_after_b", 32'(awready_o), 32'd1);
    endtask

    // mode: 0 rready always 1, 1 toggles 1/0, 2 random. abort_beat >= 0 resets on that beat.
    task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input int mode, input int abort_beat);
        bit          stalled;
        bit          rr;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        stalled = 1'b0; s_data = '0; s_resp = '0; s_last = 1'b0;
        @(negedge clk);
        arid_i = id; araddr_i = addr; arlen_i = 4'(len); arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        for (int c = 0; c < 100 && !arready_o; c++) @(negedge clk);
        check("arready", 32'(arready_o), 32'd1);
        @(negedge clk);
        arvalid_i = 1'b0;
        check("r_fetch", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        check("r_latency", 32'(rvalid_o), 32'd1);
        rd_n = 0;
        for (int c = 0; c < 400 && rd_n <= len; c++) begin
            if (rvalid_o) begin
                if (stalled) begin
                    check("hold_data", rdata_o, s_data);
                    check("hold_resp", 32'(rresp_o), 32'(s_resp));
                    check("hold_last", 32'(rlast_o), 32'(s_last));
                end
                if (rd_n == abort_beat) begin
                    rst_n = 1'b0;
                    #1;
                    return;
                end
                if (mode == 0)      rr = 1'b1;
                else if (mode == 1) rr = (c % 2) == 0;
                else                rr = $urandom_range(0, 1) == 1;
                rready_i = rr;
                if (rr) begin
                    rd_data[rd_n] = rdata_o; rd_resp[rd_n] = rresp_o;
                    rd_last[rd_n] = rlast_o; rd_id[rd_n]   = rid_o;
                    rd_n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_data = rdata_o; s_resp = rresp_o; s_last = rlast_o;
                end
            end else begin
                rready_i = 1'b0;
            end
            @(negedge clk);
        end
        rready_i = 1'b0;
        check("r_beats", 32'(rd_n), 32'(len + 1));
        check("r_idle", 32'(rvalid_o), 32'd0);
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [2:0] size,
                              input logic [ID_W-1:0] id);
        for (int i = 0; i <= len && i < rd_n; i++) begin
            check({tag, "_data"}, rd_data[i], exp_rdata(addr, i));
            check({tag, "_resp"}, 32'(rd_resp[i]), 32'(exp_rresp(addr, i, burst, size)));
            check({tag, "_last"}, 32'(rd_last[i]), 32'(i == len));
            check({tag, "_rid"}, 32'(rd_id[i]), 32'(id));
        end
    endtask

    logic [1:0]  exp_b;
    logic [31:0] a;
    int          len;
    logic [1:0]  burst;
    logic [ID_W-1:0] id;

    initial begin
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
        rready_i = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_awready", 32'(awready_o), 32'd1);
        check("rst_arready", 32'(arready_o), 32'd1);
        check("rst_wready",  32'(wready_o),  32'd0);
        check("rst_bvalid",  32'(bvalid_o),  32'd0);
        check("rst_rvalid",  32'(rvalid_o),  32'd0);
        check("rst_rdata",   rdata_o,        32'd0);
        check("rst_rlast",   32'(rlast_o),   32'd0);
        check("rst_bresp",   32'(bresp_o),   32'd0);
        check("rst_rresp",   32'(rresp_o),   32'd0);
        check("rst_bid",     32'(bid_o),     32'd0);
        check("rst_rid",     32'(rid_o),     32'd0);
        rst_n = 1'b1;

        // fill the whole memory so every later read has a known expectation
        for (int blk = 0; blk < int'(DEPTH / 16); blk++) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
            exp_b = model_write(32'(blk * 64), 15, BURST_INCR, SIZE_4B, -1);
            axi_write(4'(blk), 32'(blk * 64), 15, BURST_INCR, SIZE_4B, -1);
            check("pre_bresp", 32'(wr_resp), 32'(exp_b));
        end

        // single beat
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        exp_b = model_write(32'h100, 0, BURST_INCR, SIZE_4B, -1);
        axi_write(4'h5, 32'h100, 0, BURST_INCR, SIZE_4B, -1);
        check("single_bresp", 32'(wr_resp), 32'(RESP_OKAY));
        check("single_bid", 32'(wr_id), 32'h5);
        axi_read(4'h9, 32'h100, 0, BURST_INCR, SIZE_4B, 0, -1);
        check("single_rdata", rd_data[0], 32'hDEADBEEF);
        check("single_rlast", 32'(rd_last[0]), 32'd1);
        check("single_rresp", 32'(rd_resp[0]), 32'(RESP_OKAY));
        check("single_rid", 32'(rd_id[0]), 32'h9);

        // 16-beat burst, read back with rready toggling
        for (int i = 0; i < 16; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
        exp_b = model_write(32'h2000, 15, BURST_INCR, SIZE_4B, -1);
        axi_write(4'h3, 32'h2000, 15, BURST_INCR, SIZE_4B, -1);
        check("burst_bresp", 32'(wr_resp), 32'(RESP_OKAY));
        axi_read(4'hA, 32'h2000, 15, BURST_INCR, SIZE_4B, 1, -1);
        for (int i = 0; i < 16; i++) begin
            check("burst_data", rd_data[i], 32'(i));
            check("burst_last", 32'(rd_last[i]), 32'(i == 15));
        end

        // byte strobes
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        exp_b = model_write(32'h40, 0, BURST_INCR, SIZE_4B, -1);
        axi_write(4'h1, 32'h40, 0, BURST_INCR, SIZE_4B, -1);
        wbuf[0] = 32'h0; sbuf[0] = 4'b0101;
        exp_b = model_write(32'h40, 0, BURST_INCR, SIZE_4B, -1);
        axi_write(4'h1, 32'h40, 0, BURST_INCR, SIZE_4B, -1);
        axi_read(4'h2, 32'h40, 0, BURST_INCR, SIZE_4B, 0, -1);
        check("strobe_data", rd_data[0], 32'hFF00FF00);

        // FIXED burst
        for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        exp_b = model_write(32'h500, 1, BURST_FIXED, SIZE_4B, -1);
        axi_write(4'h4, 32'h500, 1, BURST_FIXED, SIZE_4B, -1);
        check("fixed_bresp", 32'(wr_resp), 32'(RESP_SLVERR));

        // read running off the end of memory
        axi_read(4'hB, MEM_BYTES - 8, 3, BURST_INCR, SIZE_4B, 0, -1);
        check_read("edge", MEM_BYTES - 8, 3, BURST_INCR, SIZE_4B, 4'hB);
        check("edge_b2_resp", 32'(rd_resp[2]), 32'(RESP_SLVERR));
        check("edge_b3_data", rd_data[3], 32'd0);
        check("edge_b1_resp", 32'(rd_resp[1]), 32'(RESP_OKAY));

        // write running off the end: in-range beat lands, response is SLVERR
        for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        exp_b = model_write(MEM_BYTES - 4, 1, BURST_INCR, SIZE_4B, -1);
        axi_write(4'hD, MEM_BYTES - 4, 1, BURST_INCR, SIZE_4B, -1);
        check("wedge_bresp", 32'(wr_resp), 32'(RESP_SLVERR));

        // early wlast on beat 1 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        exp_b = model_write(32'h600, 3, BURST_INCR, SIZE_4B, 1);
        axi_write(4'h8, 32'h600, 3, BURST_INCR, SIZE_4B, 1);
        check("wlast_bresp", 32'(wr_resp), 32'(RESP_SLVERR));
        axi_read(4'h8, 32'h600, 3, BURST_INCR, SIZE_4B, 0, -1);
        check_read("wlast_rb", 32'h600, 3, BURST_INCR, SIZE_4B, 4'h8);

        // concurrent write burst and read burst on disjoint regions
        for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        exp_b = model_write(32'h3000, 15, BURST_INCR, SIZE_4B, -1);
        fork
            axi_write(4'h6, 32'h3000, 15, BURST_INCR, SIZE_4B, -1);
            axi_read(4'hC, 32'h0, 15, BURST_INCR, SIZE_4B, 2, -1);
        join
        check("conc_bresp", 32'(wr_resp), 32'(RESP_OKAY));
        check("conc_bid", 32'(wr_id), 32'h6);
        check_read("conc_rd", 32'h0, 15, BURST_INCR, SIZE_4B, 4'hC);
        axi_read(4'h7, 32'h3000, 15, BURST_INCR, SIZE_4B, 0, -1);
        check_read("conc_wr", 32'h3000, 15, BURST_INCR, SIZE_4B, 4'h7);

        // randomized write/read-back pairs
        for (int k = 0; k < 10; k++) begin
            a     = 32'($urandom_range(0, DEPTH - 1)) * 4;
            len   = int'($urandom_range(0, 15));
            burst = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : BURST_INCR;
            id    = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
            exp_b = model_write(a, len, burst, SIZE_4B, -1);
            axi_write(id, a, len, burst, SIZE_4B, -1);
            check("rnd_bresp", 32'(wr_resp), 32'(exp_b));
            check("rnd_bid", 32'(wr_id), 32'(id));
            axi_read(~id, a, len, BURST_INCR, SIZE_4B, 2, -1);
            check_read("rnd_rd", a, len, BURST_INCR, SIZE_4B, ~id);
        end

        // reset during beat 2 of an 8-beat read
        axi_read(4'h7, 32'h2000, 7, BURST_INCR, SIZE_4B, 0, 2);
        check("abort_b0", rd_data[0], 32'd0);
        check("abort_b1", rd_data[1], 32'd1);
        check("abort_rvalid", 32'(rvalid_o), 32'd0);
        check("abort_rlast", 32'(rlast_o), 32'd0);
        check("abort_rdata", rdata_o, 32'd0);
        check("abort_bvalid", 32'(bvalid_o), 32'd0);
        check("abort_arready", 32'(arready_o), 32'd1);
        rready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_arready", 32'(arready_o), 32'd1);
        check("post_rst_awready", 32'(awready_o), 32'd1);
        axi_read(4'h5, 32'h2000, 7, BURST_INCR, SIZE_4B, 0, -1);
        check_read("post_rst", 32'h2000, 7, BURST_INCR, SIZE_4B, 4'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
